qtable_arbiter: RTL

Shares the single-port Q-table BRAM between the learning control unit (agent port) and the host configuration/readback port. Agent reads fetch all four action Q-values of one state as a 4-beat burst; agent writes update one (state, action) entry. Host accesses are single-word. Fixed agent priority, with a starvation limit that guarantees the host a slot during long learning runs.

---
 rtl/qtable_pkg.sv | 33 +++
 rtl/qtable_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/qtable_pkg.sv
// ============================================================================
// Module      : qtable_pkg
// Description : Shared types and helpers for the Q-table BRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qtable_pkg;

  localparam int NUM_ACT     = 4;
  localparam int ACT_WIDTH   = 2;
  localparam int DEF_Q_WIDTH = 16;
  localparam int DEF_S_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AG_RD   = 3'd1,
    ST_AG_WAIT = 3'd2,
    ST_AG_WR   = 3'd3,
    ST_HO_RD   = 3'd4,
    ST_HO_WAIT = 3'd5,
    ST_HO_WR   = 3'd6
  } state_t;

  // BRAM word address: state index in the upper bits, action in the low bits
  function automatic logic [31:0] qt_addr(input logic [29:0] state,
                                          input logic [ACT_WIDTH-1:0] act);
    return {state, act};
  endfunction

endpackage

`default_nettype wire

// File: rtl/qtable_arbiter.sv
// ============================================================================
// Module      : qtable_arbiter
// Description : Single-port Q-table BRAM arbiter, agent priority with host
//               starvation limit; 4-beat agent state reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qtable_arbiter
  import qtable_pkg::*;
#(
  parameter int S_WIDTH    = DEF_S_WIDTH,
  parameter int Q_WIDTH    = DEF_Q_WIDTH,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     agent_req,
  input  logic                     agent_we,
  input  logic [S_WIDTH-1:0]       agent_state,
  input  logic [ACT_WIDTH-1:0]     agent_act,
  input  logic [Q_WIDTH-1:0]       agent_wdata,
  output logic                     agent_gnt,
  output logic                     agent_rvalid,
  output logic [NUM_ACT*Q_WIDTH-1:0] agent_rdata,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [S_WIDTH+1:0]       host_addr,
  input  logic [Q_WIDTH-1:0]       host_wdata,
  output logic                     host_gnt,
  output logic                     host_rvalid,
  output logic [Q_WIDTH-1:0]       host_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [S_WIDTH+1:0]       ram_addr,
  output logic [Q_WIDTH-1:0]       ram_wdata,
  input  logic [Q_WIDTH-1:0]       ram_rdata,
  output logic                     busy
);

  localparam int       A_WIDTH    = S_WIDTH + ACT_WIDTH;
  localparam logic [7:0] C_STARVE = 8'(STARVE_MAX);

  state_t                       r_state;
  logic [A_WIDTH-1:0]           r_addr;
  logic [Q_WIDTH-1:0]           r_wdata;
  logic [3*Q_WIDTH-1:0]         r_buf;
  logic [7:0]                   r_starve_cnt;
  logic                         w_idle;
  logic                         w_host_win;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_host_win = host_req && (!agent_req || (r_starve_cnt == C_STARVE));
  assign agent_gnt  = w_idle && agent_req && !w_host_win;
  assign host_gnt   = w_idle && w_host_win;
  assign busy       = !w_idle;

  assign ram_en    = r_state inside {ST_AG_RD, ST_AG_WR, ST_HO_RD, ST_HO_WR};
  assign ram_we    = r_state inside {ST_AG_WR, ST_HO_WR};
  assign ram_addr  = ram_en ? r_addr  : '0;
  assign ram_wdata = ram_we ? r_wdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (host_gnt) begin
      r_starve_cnt <= '0;
    end else if (host_req && (r_starve_cnt != C_STARVE)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // During a burst the low address bits double as the beat counter; beat k
  // returns from the BRAM while beat k+1 is being issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_buf        <= '0;
      agent_rvalid <= 1'b0;
      agent_rdata  <= '0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      agent_rvalid <= 1'b0;
      host_rvalid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (agent_gnt) begin
            r_addr  <= A_WIDTH'(qt_addr(30'(agent_state), agent_we ? agent_act : 2'd0));
            r_wdata <= agent_wdata;
            r_state <= agent_we ? ST_AG_WR : ST_AG_RD;
          end else if (host_gnt) begin
            r_addr  <= host_addr;
            r_wdata <= host_wdata;
            r_state <= host_we ? ST_HO_WR : ST_HO_RD;
          end
        end
        ST_AG_RD: begin
          if (r_addr[1:0] != 2'd0) begin
            r_buf <= {ram_rdata, r_buf[3*Q_WIDTH-1:Q_WIDTH]};
          end
          r_addr[1:0] <= r_addr[1:0] + 2'd1;
          if (r_addr[1:0] == 2'd3) begin
            r_state <= ST_AG_WAIT;
          end
        end
        ST_AG_WAIT: begin
          agent_rdata  <= {ram_rdata, r_buf};
          agent_rvalid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        ST_HO_RD: begin
          r_state <= ST_HO_WAIT;
        end
        ST_HO_WAIT: begin
          host_rdata  <= ram_rdata;
          host_rvalid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_AG_WR, ST_HO_WR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
